// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: mode encodings, direction constants and per-mode seed patterns
package led_pattern_pkg;
  typedef enum logic [2:0] {SCAN, COUNT, GRAY, BAR, BLINK} t_mode;
  localparam int NUM_MODES = 5;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
  function automatic logic [15:0] seed_of(input t_mode m, input int n);
    logic [15:0] s;
    s = (m == BLINK) ? 16'h5555 : (m == SCAN) ? 16'h0001 : 16'h0000;
    return s & 16'((32'd1 << n) - 32'd1);
  endfunction
endpackage

// File: rtl/led_pattern_gen_edge_detect.sv
// led_edge_detect: registers the key level and flags its rising edge
module led_edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic press_o
);
  logic btn_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) btn_q <= RST_VAL;
    else     btn_q <= in_i;
  assign press_o = in_i & ~btn_q;
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: five-mode LED animation sequencer stepped by the slow clock
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS = 8
) (
  input  logic                slow_clk,
  input  logic                rst,
  input  logic                mode_btn_i,
  input  logic                hold_i,
  output logic [NUM_LEDS-1:0] pattern_o,
  output logic [2:0]          mode_o,
  output logic                wrap_o
);
  localparam int N = NUM_LEDS;
  localparam logic [N-1:0] ONE = N'(1);
  localparam logic [N-1:0] TOP = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] SEED_BLINK = N'(seed_of(BLINK, N));
  logic [N-1:0] pattern_q, pattern_d, cnt_q, cnt_d;
  logic [2:0] mode_q, mode_d;
  logic dir_q, dir_d, wrap_q, wrap_d, press;
  led_edge_detect #(.RST_VAL(1'b1)) u_edge (
    .clk    (slow_clk),
    .rst    (rst),
    .in_i   (mode_btn_i),
    .press_o(press)
  );
  always_ff @(posedge slow_clk or posedge rst)
    if (rst) begin
      mode_q    <= SCAN;
      pattern_q <= ONE;
      dir_q     <= DIR_UP;
      cnt_q     <= '0;
      wrap_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      wrap_q    <= wrap_d;
    end
  // a press wins over hold; encodings past BLINK animate as SCAN
  always_comb begin
    mode_d    = mode_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    wrap_d    = 1'b0;
    if (press) begin
      mode_d    = (mode_q >= 3'(NUM_MODES - 1)) ? SCAN : mode_q + 3'd1;
      pattern_d = N'(seed_of(t_mode'(mode_d), N));
      dir_d     = DIR_UP;
      cnt_d     = '0;
    end else if (!hold_i) begin
      case (mode_q)
        COUNT: begin
          pattern_d = pattern_q + ONE;
          wrap_d    = pattern_d == '0;
        end
        GRAY: begin
          cnt_d     = cnt_q + ONE;
          pattern_d = cnt_d ^ (cnt_d >> 1);
          wrap_d    = cnt_d == '0;
        end
        BAR: begin
          if (dir_q == DIR_UP) begin
            dir_d     = &pattern_q ? DIR_DN : DIR_UP;
            pattern_d = &pattern_q ? pattern_q >> 1 : {pattern_q[N-2:0], 1'b1};
          end else begin
            dir_d     = (pattern_q == '0) ? DIR_UP : DIR_DN;
            pattern_d = (pattern_q == '0) ? ONE : pattern_q >> 1;
          end
          wrap_d = pattern_d == '0;
        end
        BLINK: begin
          pattern_d = ~pattern_q;
          wrap_d    = pattern_d == SEED_BLINK;
        end
        default: begin
          if (dir_q == DIR_UP) begin
            dir_d     = (pattern_q == TOP) ? DIR_DN : DIR_UP;
            pattern_d = (pattern_q == TOP) ? pattern_q >> 1 : pattern_q << 1;
          end else begin
            dir_d     = (pattern_q == ONE) ? DIR_UP : DIR_DN;
            pattern_d = (pattern_q == ONE) ? pattern_q << 1 : pattern_q >> 1;
          end
          wrap_d = pattern_d == ONE;
        end
      endcase
    end
  end
  assign pattern_o = pattern_q;
  assign mode_o    = mode_q;
  assign wrap_o    = wrap_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: position-in-period model plus directed literal checks
module tb_led_pattern_gen;
  localparam int N = 8;
  logic slow_clk = 1'b0, rst = 1'b1, mode_btn = 1'b0, hold = 1'b0;
  logic [N-1:0] pattern;
  logic [2:0] mode;
  logic wrap;
  int checks = 0, errors = 0;
  int m_mode = 0, m_k = 0;
  logic m_wrap = 1'b0, m_btn = 1'b1;
  led_pattern_gen #(.NUM_LEDS(N)) dut (
    .slow_clk  (slow_clk),
    .rst       (rst),
    .mode_btn_i(mode_btn),
    .hold_i    (hold),
    .pattern_o (pattern),
    .mode_o    (mode),
    .wrap_o    (wrap)
  );
  always #5 slow_clk = ~slow_clk;
  function automatic int per(int m);
    return (m == 1 || m == 2) ? (1 << N) : (m == 3) ? 2 * N : (m == 4) ? 2 : 2 * N - 2;
  endfunction
  function automatic logic [N-1:0] exp_pat(int m, int k);
    int v;
    v = 0;
    case (m)
      1: v = k;
      2: v = k ^ (k >> 1);
      3: v = (k <= N) ? (1 << k) - 1 : (1 << (2 * N - k)) - 1;
      4: begin
        for (int i = 0; i < N; i += 2) v |= 1 << i;
        if (k % 2 == 1) v = ~v;
      end
      default: v = (k < N) ? 1 << k : 1 << (2 * N - 2 - k);
    endcase
    return N'(v);
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  always @(posedge slow_clk or posedge rst)
    if (rst) begin
      m_mode <= 0;
      m_k    <= 0;
      m_wrap <= 1'b0;
      m_btn  <= 1'b1;
    end else begin
      m_btn <= mode_btn;
      if (mode_btn && !m_btn) begin
        m_mode <= (m_mode == 4) ? 0 : m_mode + 1;
        m_k    <= 0;
        m_wrap <= 1'b0;
      end else if (hold) begin
        m_wrap <= 1'b0;
      end else begin
        m_k    <= (m_k + 1) % per(m_mode);
        m_wrap <= ((m_k + 1) % per(m_mode)) == 0;
      end
    end
  always @(negedge slow_clk) begin
    check("model_pattern", pattern, exp_pat(m_mode, m_k));
    check("model_mode", mode, m_mode);
    check("model_wrap", wrap, m_wrap);
  end
  task automatic step(input int n);
    repeat (n) @(negedge slow_clk);
  endtask
  task automatic press();
    mode_btn = 1'b1;
    step(1);
    mode_btn = 1'b0;
  endtask
  initial begin
    int w;
    int gs[4] = '{1, 3, 2, 6};
    step(1);
    check("reset_pattern", pattern, 1);
    check("reset_mode", mode, 0);
    check("reset_wrap", wrap, 0);
    rst = 1'b0;
    w = 0;
    for (int i = 1; i <= 14; i++) begin
      step(1);
      w += int'(wrap);
      if (i == 7) check("scan_top", pattern, 128);
    end
    check("scan_end", pattern, 1);
    check("scan_wrap_end", wrap, 1);
    check("scan_wrap_count", w, 1);
    mode_btn = 1'b1;
    step(1);
    check("count_mode", mode, 1);
    check("count_seed", pattern, 0);
    step(3);
    check("count_long_press", pattern, 3);
    mode_btn = 1'b0;
    step(252);
    check("count_255", pattern, 255);
    step(1);
    check("count_wrap_pat", pattern, 0);
    check("count_wrap", wrap, 1);
    press();
    check("gray_mode", mode, 2);
    check("gray_seed", pattern, 0);
    foreach (gs[i]) begin
      step(1);
      check("gray_step", pattern, gs[i]);
    end
    press();
    check("bar_mode", mode, 3);
    check("bar_seed", pattern, 0);
    step(8);
    check("bar_full", pattern, 255);
    step(1);
    check("bar_down", pattern, 127);
    step(6);
    check("bar_one", pattern, 1);
    step(1);
    check("bar_zero", pattern, 0);
    check("bar_wrap", wrap, 1);
    press();
    check("blink_mode", mode, 4);
    check("blink_seed", pattern, 8'h55);
    check("blink_seed_wrap", wrap, 0);
    step(1);
    check("blink_inv", pattern, 8'hAA);
    step(1);
    check("blink_back", pattern, 8'h55);
    check("blink_wrap", wrap, 1);
    press();
    check("loop_mode", mode, 0);
    check("loop_seed", pattern, 1);
    step(3);
    check("scan_8", pattern, 8);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("hold_pattern", pattern, 8);
      check("hold_wrap", wrap, 0);
    end
    hold = 1'b0;
    step(1);
    check("hold_release", pattern, 16);
    hold = 1'b1;
    mode_btn = 1'b1;
    step(1);
    check("hold_press_mode", mode, 1);
    check("hold_press_seed", pattern, 0);
    step(1);
    check("hold_keep_mode", mode, 1);
    check("hold_keep_pat", pattern, 0);
    mode_btn = 1'b0;
    hold = 1'b0;
    step(77);
    check("count_77", pattern, 77);
    #2 rst = 1'b1;
    mode_btn = 1'b1;
    #1;
    check("async_rst_pattern", pattern, 1);
    check("async_rst_mode", mode, 0);
    step(1);
    rst = 1'b0;
    step(1);
    check("btn_through_rst_mode", mode, 0);
    check("first_step_after_rst", pattern, 2);
    mode_btn = 1'b0;
    step(1);
    mode_btn = 1'b1;
    step(1);
    check("press_after_rst", mode, 1);
    mode_btn = 1'b0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Multi-mode LED pattern sequencer clocked by the slow (few-Hz) clock from the clock generator. It drives the board LED bank directly and replaces a single fixed scanner with five selectable animations. A debounced push-button steps through modes, and a hold input freezes the animation. The block sits between the debounced key / slow clock sources and the LED output pins; the top level inverts the pattern as needed for active-low LEDs.

## Interface
- NUM_LEDS, 8, pattern width; legal range 3..16.
- slow_clk  in  1  sequencing clock; every animation step is one rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mode_btn  in  1  debounced mode key, active-high level; sampled on slow_clk.
- hold  in  1  active-high; freezes the animation while high.
- pattern  out  NUM_LEDS  registered LED pattern; 1 = LED on.
- mode  out  3  current mode encoding, registered.
- wrap  out  1  registered one-cycle pulse; marks the end of an animation period.

## Operation
- Reset values (asynchronous):
  - mode = SCAN(0), pattern = 1, dir = up, cnt = 0, wrap = 0.
  - btn_q = 1, so a key held through reset does not register as a press.
- Button edge: press = mode_btn & ~btn_q; btn_q <= mode_btn every cycle.
- On a press:
  - mode <= (mode == BLINK) ? SCAN : mode+1.
  - The new mode's seed is loaded into pattern, dir and cnt on the same edge; wrap = 0.
  - A press overrides hold, so the seed loads even while frozen.
- hold = 1 with no press: all state is held and wrap = 0.
- Otherwise the animation advances one step per edge, per mode:
  - SCAN(0):
    - Seed pattern = 1, dir = up.
    - While going up, shift left; when pattern == 1<<(N-1), set dir = down and shift right.
    - While going down, shift right; when pattern == 1, set dir = up and shift left.
    - Period 2N-2. wrap = 1 on the edge that loads pattern = 1.
  - COUNT(1): seed 0; pattern = pattern+1, modulo 2^N. wrap = 1 on the edge that loads 0.
  - GRAY(2):
    - Seed cnt = 0; cnt = cnt+1 modulo 2^N.
    - pattern = next_cnt ^ (next_cnt>>1), registered in step with cnt.
    - wrap = 1 when cnt wraps to 0.
  - BAR(3):
    - Seed 0, dir = up.
    - Up: pattern = (pattern<<1)|1. When pattern is all ones, set dir = down and shift right on that step.
    - Down: pattern >>= 1. At 0, set dir = up and fill on that step.
    - Period 2N. wrap = 1 on the edge that loads 0.
  - BLINK(4): seed is alternating 0101…, LSB = 1; pattern = ~pattern each step. wrap = 1 on the edge that returns to the seed.
- Mode encodings 5..7 are unreachable. If entered, they decode as SCAN behaviour and step to SCAN on the next press.
- Width rules:
  - All shifts are logical and truncated to N bits.
  - cnt is N bits wide.
  - dir is meaningful only in SCAN and BAR. It is forced to up when any seed loads.

## Timing
- All outputs are registered, with no combinational path from any input to any output.
- Press latency: mode_btn rises before edge k → mode and the seed pattern are visible after edge k.
- A press lasting several cycles counts once. A new press needs mode_btn low for at least one sampled edge.
- hold takes effect on the first edge where it is sampled high. Release resumes from the frozen state, with no skipped step.
- wrap is high for exactly one cycle per period and never on a seed reload.
- Reset mid-animation: outputs return to reset values immediately, independent of the clock. The first step after release is SCAN 1→2.

## Structure
- Package led_pattern_pkg:
  - typedef enum logic [2:0] t_mode {SCAN, COUNT, GRAY, BAR, BLINK}.
  - Constant NUM_MODES = 5.
  - Function seed_of(t_mode, N).
- Sub-module led_edge_detect: btn_q register plus rising-edge pulse, with the reset value as a parameter (1 here).
- Core: one always_ff for the registers, one always_comb computing the next state per mode.

## Test plan
- Reset release, N=8, hold = 0, no press:
  - pattern runs 1,2,4,…,128,64,…,2,1.
  - wrap is high only on the return to 1, 14 cycles after release.
- One press from SCAN:
  - mode = 1 and pattern = 0 after the next edge.
  - pattern then counts 1,2,3…; wrap fires when 255→0.
- Mode 2, 4 steps:
  - pattern runs 0,1,3,2,6.
  - Five presses starting from SCAN return mode to 0 with pattern = 1.
- BAR mode: pattern runs 0,1,3,…,255,127,…,1,0; wrap fires on 0 after 16 steps. BLINK alternates 0x55 / 0xAA.
- Hold and simultaneous events:
  - hold = 1 mid-SCAN at pattern = 8: pattern stays 8 for 10 cycles, then 16 after release.
  - Press during hold: the seed loads anyway.
- mode_btn held through reset release gives no mode change. Assert rst mid-COUNT at pattern = 77: pattern reads 1 and mode reads 0 without any clock edge.
